// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the issue-unit FSM encoding.
// Imported by the issue unit and by anything that models the ALU it drives.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXECUTE,
        ST_WRITEBACK
    } state_t;

    function automatic logic is_supported(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Fetch handshake, ALU control/operand bus and retire report of the issue unit.
// master is the issue unit itself; slave is the fetch/ALU/retire environment.
interface alu_issue_unit_if #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [31:0]           instr;
    logic [6:0]            alu_funct7;
    logic [2:0]            alu_funct3;
    logic [WORD_SIZE-1:0]  alu_source1;
    logic [WORD_SIZE-1:0]  alu_source2;
    logic [WORD_SIZE-1:0]  alu_result;
    logic                  retire_valid;
    logic [REG_ADDR_W-1:0] retire_rd;
    logic [WORD_SIZE-1:0]  retire_data;
    logic                  illegal;

    modport master (
        input  instr_valid, instr, alu_result,
        output instr_ready, alu_funct7, alu_funct3, alu_source1, alu_source2,
        output retire_valid, retire_rd, retire_data, illegal
    );

    modport slave (
        output instr_valid, instr, alu_result,
        input  instr_ready, alu_funct7, alu_funct3, alu_source1, alu_source2,
        input  retire_valid, retire_rd, retire_data, illegal
    );
endinterface

// File: rtl/alu_issue_unit_regfile.sv
// Integer register file: two combinational read ports, one synchronous write
// port and a debug read port; x0 always reads zero and ignores writes.
module regfile #(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WORD_SIZE-1:0]  wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    output logic [WORD_SIZE-1:0]  rdata1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [WORD_SIZE-1:0]  rdata2,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WORD_SIZE-1:0]  dbg_data
);
    logic [WORD_SIZE-1:0] mem [2**REG_ADDR_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**REG_ADDR_W; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = (raddr1   == '0) ? '0 : mem[raddr1];
    assign rdata2   = (raddr2   == '0) ? '0 : mem[raddr2];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_unit.sv
// Multi-cycle, non-pipelined issue unit: accepts one RV32I OP/OP-IMM
// instruction, drives the external ALU and writes its result back to rd.
module alu_issue_unit
    import riscv_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_issue_unit_if.master      bus,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WORD_SIZE-1:0]  dbg_data
);
    state_t                state, state_next;
    logic [31:0]           instr_q;
    logic                  illegal_q;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rd, rs1, rs2;
    logic [WORD_SIZE-1:0]  rf_rdata1, rf_rdata2;
    logic                  rf_we;

    logic                  dec_legal;
    logic [6:0]            dec_funct7;
    logic [WORD_SIZE-1:0]  dec_source2;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign rd     = instr_q[7  +: REG_ADDR_W];
    assign rs1    = instr_q[15 +: REG_ADDR_W];
    assign rs2    = instr_q[20 +: REG_ADDR_W];

    assign bus.instr_ready = rst_n && (state == ST_IDLE);
    assign rf_we = (state == ST_WRITEBACK) && !illegal_q && (rd != '0);

    regfile #(
        .WORD_SIZE (WORD_SIZE),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (bus.retire_data),
        .raddr1  (rs1),
        .rdata1  (rf_rdata1),
        .raddr2  (rs2),
        .rdata2  (rf_rdata2),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    // OP-IMM only forwards funct7 for shifts, otherwise ADDI with a negative
    // immediate would look like SUB to the ALU.
    always_comb begin
        dec_legal   = is_supported(opcode);
        dec_funct7  = '0;
        dec_source2 = '0;
        if (opcode == OPC_OP) begin
            dec_funct7  = instr_q[31:25];
            dec_source2 = rf_rdata2;
        end else if (opcode == OPC_OP_IMM) begin
            dec_funct7  = (funct3 == F3_SRL_SRA) ? instr_q[31:25] : 7'd0;
            dec_source2 = {{(WORD_SIZE-12){instr_q[31]}}, instr_q[31:20]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (bus.instr_valid) state_next = ST_DECODE;
            ST_DECODE:    state_next = ST_EXECUTE;
            ST_EXECUTE:   state_next = ST_WRITEBACK;
            ST_WRITEBACK: state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // ALU outputs only change in DECODE; retire fields are loaded at the end
    // of EXECUTE so they are presented together during WRITEBACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q          <= '0;
            illegal_q        <= 1'b0;
            bus.alu_funct7   <= '0;
            bus.alu_funct3   <= '0;
            bus.alu_source1  <= '0;
            bus.alu_source2  <= '0;
            bus.retire_valid <= 1'b0;
            bus.retire_rd    <= '0;
            bus.retire_data  <= '0;
            bus.illegal      <= 1'b0;
        end else begin
            bus.retire_valid <= 1'b0;
            bus.illegal      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) instr_q <= bus.instr;
                end
                ST_DECODE: begin
                    illegal_q       <= !dec_legal;
                    bus.alu_funct7  <= dec_legal ? dec_funct7 : 7'd0;
                    bus.alu_funct3  <= dec_legal ? funct3 : 3'd0;
                    bus.alu_source1 <= dec_legal ? rf_rdata1 : '0;
                    bus.alu_source2 <= dec_legal ? dec_source2 : '0;
                end
                ST_EXECUTE: begin
                    bus.retire_valid <= 1'b1;
                    bus.retire_rd    <= rd;
                    bus.illegal      <= illegal_q;
                    bus.retire_data  <= (illegal_q || (rd == '0)) ? '0 : bus.alu_result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: directed instructions push expected
// retire records, a negedge monitor pops and compares them at every retire.
module tb_alu_issue_unit;
    import riscv_pkg::*;

    localparam int WORD_SIZE  = 32;
    localparam int REG_ADDR_W = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [REG_ADDR_W-1:0] dbg_addr;
    logic [WORD_SIZE-1:0]  dbg_data;

    alu_issue_unit_if #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) bus ();

    alu_issue_unit #(.WORD_SIZE(WORD_SIZE), .REG_ADDR_W(REG_ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    typedef struct {
        logic [31:0] word;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        ill;
        int          hs;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Reference ALU standing in for the real one on the other side of the bus.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_funct3)
            F3_ADD_SUB: bus.alu_result = bus.alu_funct7[5] ? bus.alu_source1 - bus.alu_source2
                                                           : bus.alu_source1 + bus.alu_source2;
            F3_SLL:     bus.alu_result = bus.alu_source1 << bus.alu_source2[4:0];
            F3_SLT:     bus.alu_result = {31'd0, $signed(bus.alu_source1) < $signed(bus.alu_source2)};
            F3_SLTU:    bus.alu_result = {31'd0, bus.alu_source1 < bus.alu_source2};
            F3_XOR:     bus.alu_result = bus.alu_source1 ^ bus.alu_source2;
            F3_SRL_SRA: bus.alu_result = bus.alu_funct7[5] ? ($signed(bus.alu_source1) >>> bus.alu_source2[4:0])
                                                           : (bus.alu_source1 >> bus.alu_source2[4:0]);
            F3_OR:      bus.alu_result = bus.alu_source1 | bus.alu_source2;
            F3_AND:     bus.alu_result = bus.alu_source1 & bus.alu_source2;
            default:    bus.alu_result = '0;
        endcase
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        else passes++;
    endtask

    task automatic applyStimulus(input logic [31:0] word, input logic [6:0] f7, input logic [2:0] f3,
                                 input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] rd,
                                 input logic [31:0] data, input logic ill, input bit expect_retire,
                                 output int hs);
        int   waited;
        exp_t e;
        @(negedge clk);
        bus.instr       = word;
        bus.instr_valid = 1'b1;
        waited = 0;
        while (!bus.instr_ready && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.instr_ready) begin
            checks++;
            $display("[TB] FAIL handshake_timeout %08h: instr_ready=0 after %0d cycles, expected 1", word, waited);
            hs = -1;
        end else begin
            hs = cycle + 1;
            if (expect_retire) begin
                e = '{word, f7, f3, s1, s2, rd, data, ill, hs};
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            $display("[TB] FAIL drain_timeout: %0d retires pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkReg(input logic [4:0] addr, input logic [31:0] value);
        dbg_addr = addr;
        #1;
        checkOutput($sformatf("dbg x%0d", addr), dbg_data, value);
    endtask

    // Retire monitor: every retire pulse must match the oldest expectation.
    initial begin : monitor
        exp_t e;
        bit   seen_retire;
        seen_retire = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_retire = 1'b0;
            end else begin
                if (seen_retire) checkOutput("ready_after_retire", {31'd0, bus.instr_ready}, 32'd1);
                seen_retire = 1'b0;
                if (bus.retire_valid) begin
                    seen_retire = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_retire: got retire_valid=1 rd=%0d, expected 0", bus.retire_rd);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput($sformatf("%08h retire_rd", e.word),   {27'd0, bus.retire_rd}, {27'd0, e.rd});
                        checkOutput($sformatf("%08h retire_data", e.word), bus.retire_data, e.data);
                        checkOutput($sformatf("%08h illegal", e.word),     {31'd0, bus.illegal}, {31'd0, e.ill});
                        checkOutput($sformatf("%08h alu_funct7", e.word),  {25'd0, bus.alu_funct7}, {25'd0, e.f7});
                        checkOutput($sformatf("%08h alu_funct3", e.word),  {29'd0, bus.alu_funct3}, {29'd0, e.f3});
                        checkOutput($sformatf("%08h alu_source1", e.word), bus.alu_source1, e.s1);
                        checkOutput($sformatf("%08h alu_source2", e.word), bus.alu_source2, e.s2);
                        checkOutput($sformatf("%08h latency", e.word),     cycle - e.hs, 32'd2);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int hs0, hs1, hs2;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        dbg_addr        = '0;
        rst_n           = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset retire_valid", {31'd0, bus.retire_valid}, 32'd0);
        checkOutput("reset alu_source1", bus.alu_source1, 32'd0);
        checkOutput("reset instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("idle instr_ready", {31'd0, bus.instr_ready}, 32'd1);

        // ADDI x1,x0,5 with the debug port watching x1 across writeback
        dbg_addr = 5'd1;
        applyStimulus(32'h00500093, 7'h00, 3'd0, 32'd0, 32'd5, 5'd1, 32'd5, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("dbg x1 during writeback", dbg_data, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("dbg x1 after writeback", dbg_data, 32'd5);
        waitDrain();

        applyStimulus(32'h00700113, 7'h00, 3'd0, 32'd0, 32'd7, 5'd2, 32'd7, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        applyStimulus(32'h002081B3, 7'h00, 3'd0, 32'd5, 32'd7, 5'd3, 32'd12, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        applyStimulus(32'h40110233, 7'h20, 3'd0, 32'd7, 32'd5, 5'd4, 32'd2, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        applyStimulus(32'h00900013, 7'h00, 3'd0, 32'd0, 32'd9, 5'd0, 32'd0, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        applyStimulus(32'hFFF00293, 7'h00, 3'd0, 32'd0, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFF, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        applyStimulus(32'h4021D313, 7'h20, 3'd5, 32'd12, 32'h00000402, 5'd6, 32'd3, 1'b0, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        applyStimulus(32'h00000000, 7'h00, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0, 1'b1, 1'b1, hs0);
        bus.instr_valid = 1'b0;
        waitDrain();

        checkReg(5'd0, 32'd0);
        checkReg(5'd1, 32'd5);
        checkReg(5'd2, 32'd7);
        checkReg(5'd3, 32'd12);
        checkReg(5'd4, 32'd2);
        checkReg(5'd5, 32'hFFFFFFFF);
        checkReg(5'd6, 32'd3);

        // Back-to-back with instr_valid held high: OR x7, AND x8, XORI x9
        applyStimulus(32'h0020E3B3, 7'h00, 3'd6, 32'd5, 32'd7, 5'd7, 32'd7, 1'b0, 1'b1, hs0);
        applyStimulus(32'h0020F433, 7'h00, 3'd7, 32'd5, 32'd7, 5'd8, 32'd5, 1'b0, 1'b1, hs1);
        applyStimulus(32'h00314493, 7'h00, 3'd4, 32'd7, 32'd3, 5'd9, 32'd4, 1'b0, 1'b1, hs2);
        bus.instr_valid = 1'b0;
        checkOutput("accept period 1", hs1 - hs0, 32'd4);
        checkOutput("accept period 2", hs2 - hs1, 32'd4);
        waitDrain();
        checkReg(5'd7, 32'd7);
        checkReg(5'd8, 32'd5);
        checkReg(5'd9, 32'd4);

        // Reset during EXECUTE of ADDI x10,x0,10: no retire, state cleared
        applyStimulus(32'h00A00513, 7'h00, 3'd0, 32'd0, 32'd10, 5'd10, 32'd10, 1'b0, 1'b0, hs0);
        bus.instr_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midop retire_valid", {31'd0, bus.retire_valid}, 32'd0);
        checkOutput("midop alu_source2", bus.alu_source2, 32'd0);
        checkOutput("midop instr_ready", {31'd0, bus.instr_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post reset instr_ready", {31'd0, bus.instr_ready}, 32'd1);
        for (int r = 0; r <= 10; r++) begin
            checkReg(r[4:0], 32'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
